// File: rtl/ldpc_wb_seq_master.sv
`default_nettype none
// ldpc_wb_seq_master: Wishbone classic initiator executing single write, read and poll-until-match commands.
// Revision 1.0
module ldpc_wb_seq_master #(
  parameter int ACK_TIMEOUT = 255,
  parameter int POLL_MAX    = 1000,
  parameter int POLL_GAP    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [31:0] cmd_mask,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_err,
  output logic [15:0] rsp_polls,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);
  localparam logic [1:0]  OP_WRITE    = 2'b00;
  localparam logic [1:0]  OP_POLL     = 2'b10;
  localparam logic [1:0]  ERR_OK      = 2'b00;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
  localparam logic [1:0]  ERR_EXHAUST = 2'b10;
  localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] POLL_LAST   = 16'(POLL_MAX);
  localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, GAP = 2'd2, RESP = 2'd3} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op, op_nxt;
  logic [31:0] exp_dat, exp_nxt;
  logic [31:0] mask, mask_nxt;
  logic [15:0] ack_cnt, ack_cnt_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic        cmd_ready_nxt, rsp_valid_nxt;
  logic [31:0] rsp_dat_nxt;
  logic [1:0]  rsp_err_nxt;
  logic [15:0] rsp_polls_nxt;
  logic        cyc_nxt, stb_nxt, we_nxt;
  logic [31:0] adr_nxt, dat_nxt;
  logic [3:0]  sel_nxt;
  logic        go_resp;
  logic [1:0]  resp_code;
  logic        poll_miss;

  assign poll_miss = |((wbm_dat_i ^ exp_dat) & mask);

  always_comb begin
    state_nxt     = state;
    op_nxt        = op;
    exp_nxt       = exp_dat;
    mask_nxt      = mask;
    ack_cnt_nxt   = ack_cnt;
    gap_cnt_nxt   = gap_cnt;
    cmd_ready_nxt = cmd_ready;
    rsp_valid_nxt = rsp_valid;
    rsp_dat_nxt   = rsp_dat;
    rsp_err_nxt   = rsp_err;
    rsp_polls_nxt = rsp_polls;
    cyc_nxt       = wbm_cyc_o;
    stb_nxt       = wbm_stb_o;
    we_nxt        = wbm_we_o;
    adr_nxt       = wbm_adr_o;
    dat_nxt       = wbm_dat_o;
    sel_nxt       = wbm_sel_o;
    go_resp       = 1'b0;
    resp_code     = ERR_OK;

    unique case (state)
      IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_nxt     = BUS;
          cmd_ready_nxt = 1'b0;
          op_nxt        = cmd_op;
          exp_nxt       = cmd_dat;
          mask_nxt      = cmd_mask;
          adr_nxt       = cmd_adr;
          sel_nxt       = cmd_sel;
          we_nxt        = (cmd_op == OP_WRITE);
          dat_nxt       = (cmd_op == OP_WRITE) ? cmd_dat : 32'd0;
          cyc_nxt       = 1'b1;
          stb_nxt       = 1'b1;
          ack_cnt_nxt   = '0;
          rsp_polls_nxt = '0;
          rsp_dat_nxt   = '0;
          rsp_err_nxt   = ERR_OK;
        end
      end
      BUS: begin
        // stb low here only after a zero-gap poll retry: this is the mandatory idle cycle
        if (!wbm_stb_o) begin
          cyc_nxt     = 1'b1;
          stb_nxt     = 1'b1;
          ack_cnt_nxt = '0;
        end else if (wbm_ack_i) begin
          rsp_polls_nxt = rsp_polls + 16'd1;
          if (op != OP_WRITE) rsp_dat_nxt = wbm_dat_i;
          if (op == OP_POLL && poll_miss) begin
            cyc_nxt = 1'b0;
            stb_nxt = 1'b0;
            if (rsp_polls_nxt == POLL_LAST) begin
              go_resp   = 1'b1;
              resp_code = ERR_EXHAUST;
            end else if (POLL_GAP != 0) begin
              state_nxt   = GAP;
              gap_cnt_nxt = '0;
            end
          end else begin
            go_resp = 1'b1;
          end
        end else if (ack_cnt == ACK_LAST) begin
          go_resp       = 1'b1;
          resp_code     = ERR_TIMEOUT;
          rsp_polls_nxt = rsp_polls + 16'd1;
        end else begin
          ack_cnt_nxt = ack_cnt + 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = BUS;
          cyc_nxt     = 1'b1;
          stb_nxt     = 1'b1;
          ack_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end
    endcase

    if (go_resp) begin
      state_nxt     = RESP;
      rsp_err_nxt   = resp_code;
      rsp_valid_nxt = 1'b1;
      cyc_nxt       = 1'b0;
      stb_nxt       = 1'b0;
      we_nxt        = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      op        <= '0;
      exp_dat   <= '0;
      mask      <= '0;
      ack_cnt   <= '0;
      gap_cnt   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= '0;
      rsp_polls <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else begin
      state     <= state_nxt;
      op        <= op_nxt;
      exp_dat   <= exp_nxt;
      mask      <= mask_nxt;
      ack_cnt   <= ack_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_dat   <= rsp_dat_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_polls <= rsp_polls_nxt;
      wbm_cyc_o <= cyc_nxt;
      wbm_stb_o <= stb_nxt;
      wbm_we_o  <= we_nxt;
      wbm_adr_o <= adr_nxt;
      wbm_dat_o <= dat_nxt;
      wbm_sel_o <= sel_nxt;
    end
  end
endmodule
`default_nettype wire
